// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared types, constants and CRC3 helper for the ALU result link
package alu_pkg;

  // Packet type bit values
  localparam logic DATA_TYPE = 1'b0;
  localparam logic CMD_TYPE  = 1'b1;

  // Canonical single-byte error frames: {1, e[2:0], e[2:0], even parity}
  localparam logic [7:0] ERR_DATA_FRAME = 8'hC9;
  localparam logic [7:0] ERR_CRC_FRAME  = 8'hA5;
  localparam logic [7:0] ERR_OP_FRAME   = 8'h93;

  // Bit positions inside flags = {carry, overflow, zero, negative}
  localparam int FLAG_CARRY    = 3;
  localparam int FLAG_OVERFLOW = 2;
  localparam int FLAG_ZERO     = 1;
  localparam int FLAG_NEGATIVE = 0;

  // Bit positions inside err_flags = {err_data, err_crc, err_op}
  localparam int ERR_DATA_BIT = 2;
  localparam int ERR_CRC_BIT  = 1;
  localparam int ERR_OP_BIT   = 0;

  // Number of DATA packets carrying C in a normal frame
  localparam logic [2:0] FRAME_DATA_PKTS = 3'd4;

  // Packet receiver states
  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_SHIFT = 2'd1,
    RX_STOP  = 2'd2
  } rx_state_e;

  // CRC3, polynomial x^3+x+1, init 0, message consumed MSB first.
  // The message is {C[31:0], 1'b0, flags[3:0]}.
  function automatic logic [2:0] crc3(input logic [36:0] msg);
    logic [2:0] crc;
    logic       fb;
    crc = 3'b000;
    for (int i = 36; i >= 0; i--) begin
      fb  = crc[2] ^ msg[i];
      crc = {crc[1], crc[0] ^ fb, fb};
    end
    return crc;
  endfunction

endpackage

// File: rtl/alu_packet_rx.sv
// rtl/alu_packet_rx.sv - 11-bit serial packet deserialiser (start, type, 8 data, stop)
module alu_packet_rx
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sout,
  output logic       pkt_valid,
  output logic       pkt_type,
  output logic [7:0] pkt_byte,
  output logic       pkt_stop_ok,
  output logic       rx_idle
);

  rx_state_e  state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [8:0] shift_q, shift_d;
  // armed: the line has been seen high since reset or since a bad stop bit,
  // so a low level can be trusted as a real start bit
  logic       armed_q, armed_d;

  // Next-state logic for the packet FSM
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    armed_d   = armed_q;
    case (state_q)
      RX_IDLE: begin
        if (sout) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          state_d   = RX_SHIFT;
          bit_cnt_d = 4'd0;
        end
      end
      RX_SHIFT: begin
        shift_d   = {shift_q[7:0], sout};
        bit_cnt_d = bit_cnt_q + 4'd1;
        if (bit_cnt_q == 4'd8) begin
          state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        // A good stop bit keeps us armed so a start can follow with no gap
        state_d = RX_IDLE;
        armed_d = sout;
      end
      default: begin
        state_d = RX_IDLE;
        armed_d = 1'b0;
      end
    endcase
  end

  // Packet FSM registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= RX_IDLE;
      bit_cnt_q <= 4'd0;
      shift_q   <= 9'd0;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      armed_q   <= armed_d;
    end
  end

  // The strobe is a decode of the state register; the stop bit is live on sout
  assign pkt_valid   = (state_q == RX_STOP);
  assign pkt_type    = shift_q[8];
  assign pkt_byte    = shift_q[7:0];
  assign pkt_stop_ok = sout;
  assign rx_idle     = (state_q == RX_IDLE) && sout;

endmodule

// File: rtl/alu_result_rx.sv
// rtl/alu_result_rx.sv - frame decoder for ALU result and error frames
module alu_result_rx
  import alu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sout,
  output logic        result_valid,
  output logic [31:0] c_data,
  output logic [3:0]  flags,
  output logic        crc_ok,
  output logic        err_valid,
  output logic [2:0]  err_flags,
  output logic        protocol_err
);

  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 2);
  localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(TIMEOUT_CYCLES);

  logic       pkt_valid;
  logic       pkt_type;
  logic [7:0] pkt_byte;
  logic       pkt_stop_ok;
  logic       rx_idle;

  alu_packet_rx u_packet_rx (
    .clk         (clk),
    .rst_n       (rst_n),
    .sout        (sout),
    .pkt_valid   (pkt_valid),
    .pkt_type    (pkt_type),
    .pkt_byte    (pkt_byte),
    .pkt_stop_ok (pkt_stop_ok),
    .rx_idle     (rx_idle)
  );

  logic [2:0]        cnt_q, cnt_d;
  logic [31:0]       c_buf_q, c_buf_d;
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
  logic              result_valid_q, result_valid_d;
  logic [31:0]       c_data_q, c_data_d;
  logic [3:0]        flags_q, flags_d;
  logic              crc_ok_q, crc_ok_d;
  logic              err_valid_q, err_valid_d;
  logic [2:0]        err_flags_q, err_flags_d;
  logic              protocol_err_q, protocol_err_d;
  logic              frame_clear;

  // Frame assembly, classification of CMD packets and inter-packet timeout
  always_comb begin
    cnt_d          = cnt_q;
    c_buf_d        = c_buf_q;
    idle_cnt_d     = idle_cnt_q;
    result_valid_d = 1'b0;
    err_valid_d    = 1'b0;
    protocol_err_d = 1'b0;
    c_data_d       = c_data_q;
    flags_d        = flags_q;
    crc_ok_d       = crc_ok_q;
    err_flags_d    = err_flags_q;
    frame_clear    = 1'b0;

    if (pkt_valid) begin
      idle_cnt_d = '0;
      if (!pkt_stop_ok) begin
        protocol_err_d = 1'b1;
        frame_clear    = 1'b1;
      end else if (pkt_type == DATA_TYPE) begin
        if (cnt_q == FRAME_DATA_PKTS) begin
          protocol_err_d = 1'b1;
          frame_clear    = 1'b1;
        end else begin
          c_buf_d = {c_buf_q[23:0], pkt_byte};
          cnt_d   = cnt_q + 3'd1;
        end
      end else begin
        frame_clear = 1'b1;
        if (cnt_q == FRAME_DATA_PKTS && !pkt_byte[7]) begin
          result_valid_d = 1'b1;
          c_data_d       = c_buf_q;
          flags_d        = pkt_byte[6:3];
          crc_ok_d       = (crc3({c_buf_q, 1'b0, pkt_byte[6:3]}) == pkt_byte[2:0]);
        end else if (cnt_q == 3'd0 && pkt_byte[7]) begin
          // Error code is sent twice plus even parity over the whole byte
          if (!(^pkt_byte) && (pkt_byte[6:4] == pkt_byte[3:1])) begin
            err_valid_d = 1'b1;
            err_flags_d = pkt_byte[6:4];
          end else begin
            protocol_err_d = 1'b1;
          end
        end else begin
          protocol_err_d = 1'b1;
        end
      end
    end else if (rx_idle && cnt_q != 3'd0) begin
      // Fires on the first idle-high cycle beyond the allowed gap
      if (idle_cnt_q == IDLE_LIMIT) begin
        protocol_err_d = 1'b1;
        frame_clear    = 1'b1;
      end else begin
        idle_cnt_d = idle_cnt_q + 1'b1;
      end
    end else begin
      idle_cnt_d = '0;
    end

    if (frame_clear) begin
      cnt_d      = 3'd0;
      c_buf_d    = 32'd0;
      idle_cnt_d = '0;
    end
  end

  // Frame state and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q          <= 3'd0;
      c_buf_q        <= 32'd0;
      idle_cnt_q     <= '0;
      result_valid_q <= 1'b0;
      c_data_q       <= 32'd0;
      flags_q        <= 4'd0;
      crc_ok_q       <= 1'b0;
      err_valid_q    <= 1'b0;
      err_flags_q    <= 3'd0;
      protocol_err_q <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      c_buf_q        <= c_buf_d;
      idle_cnt_q     <= idle_cnt_d;
      result_valid_q <= result_valid_d;
      c_data_q       <= c_data_d;
      flags_q        <= flags_d;
      crc_ok_q       <= crc_ok_d;
      err_valid_q    <= err_valid_d;
      err_flags_q    <= err_flags_d;
      protocol_err_q <= protocol_err_d;
    end
  end

  assign result_valid = result_valid_q;
  assign c_data       = c_data_q;
  assign flags        = flags_q;
  assign crc_ok       = crc_ok_q;
  assign err_valid    = err_valid_q;
  assign err_flags    = err_flags_q;
  assign protocol_err = protocol_err_q;

endmodule
